// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-port synchronous memory between instruction fetch and data access.
// Latency : grant is combinational; read data returns READ_LATENCY cycles after the grant.
// Backpres: a requester holds req until gnt; data wins ties unless fetch has hit STARVE_LIMIT.
//
// Ports:
//   clk_i, reset_n_i                       clock, asynchronous active-low reset
//   if_req_i/if_addr_i/if_gnt_o            fetch request, address, grant
//   if_rvalid_o/if_rdata_o                 fetch read response
//   d_req_i/d_addr_i/d_wmask_i/d_wdata_i   data request (wmask==0 means read)
//   d_gnt_o/d_rvalid_o/d_rdata_o           data grant and read response
//   mem_addr_o/mem_wmask_o/mem_wdata_o     shared memory command
//   mem_rdata_i                            memory read data
// Optional macro MEM_PORT_ARBITER_STATS_EN adds stat_conflicts_o and stat_starve_wins_o.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                d_req_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W/8-1:0] d_wmask_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
`ifdef MEM_PORT_ARBITER_STATS_EN
    ,
    output logic [31:0]         stat_conflicts_o,
    output logic [31:0]         stat_starve_wins_o
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Source tag carried alongside each in-flight read.
    typedef enum logic {SRC_IF = 1'b0, SRC_D = 1'b1} src_e;

    logic [3:0]              starve_q, starve_d;
    logic                    starve_hit;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       if_rdata_q, d_rdata_q;
    logic [READ_LATENCY-1:0] pv_q;
    src_e                    ps_q [READ_LATENCY];
    logic                    push_vld;
    src_e                    push_src;
    logic                    tail_vld;
    src_e                    tail_src;

    assign starve_hit = (starve_q == LIMIT);

    // Grants are suppressed while reset is asserted so every output sits at
    // its reset value even if requesters keep their requests high.
    always_comb begin
        if_gnt_o = reset_n_i & if_req_i & (~d_req_i | starve_hit);
        d_gnt_o  = reset_n_i & d_req_i & ~if_gnt_o;
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req_i || if_gnt_o) begin
            starve_d = '0;
        end else if (!starve_hit) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Memory command mux; address and write data hold when nothing is granted.
    always_comb begin
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_wmask_o = '0;
        if (if_gnt_o) begin
            mem_addr_o = if_addr_i;
        end else if (d_gnt_o) begin
            mem_addr_o  = d_addr_i;
            mem_wmask_o = d_wmask_i;
            mem_wdata_o = d_wdata_i;
        end
    end

    // Writes occupy a pipeline slot with valid=0 so no response is produced.
    assign push_vld = if_gnt_o | (d_gnt_o & ~|d_wmask_i);
    assign push_src = d_gnt_o ? SRC_D : SRC_IF;
    assign tail_vld = pv_q[READ_LATENCY-1];
    assign tail_src = ps_q[READ_LATENCY-1];

    always_comb begin
        if_rvalid_o = tail_vld & (tail_src == SRC_IF);
        d_rvalid_o  = tail_vld & (tail_src == SRC_D);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : if_rdata_q;
        d_rdata_o   = d_rvalid_o  ? mem_rdata_i : d_rdata_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            starve_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            pv_q       <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                ps_q[i] <= SRC_IF;
            end
        end else begin
            starve_q   <= starve_d;
            addr_q     <= mem_addr_o;
            wdata_q    <= mem_wdata_o;
            if_rdata_q <= if_rdata_o;
            d_rdata_q  <= d_rdata_o;
            pv_q[0]    <= push_vld;
            ps_q[0]    <= push_src;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                ps_q[i] <= ps_q[i-1];
            end
        end
    end

`ifdef MEM_PORT_ARBITER_STATS_EN
    logic [31:0] conflicts_q, starve_wins_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            conflicts_q   <= '0;
            starve_wins_q <= '0;
        end else begin
            if (if_req_i && d_req_i) begin
                conflicts_q <= conflicts_q + 32'd1;
            end
            // Fetch can only beat a pending data request via the starvation limit.
            if (if_gnt_o && d_req_i) begin
                starve_wins_q <= starve_wins_q + 32'd1;
            end
        end
    end

    assign stat_conflicts_o   = conflicts_q;
    assign stat_starve_wins_o = starve_wins_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : directed self-checking bench for mem_port_arbiter at READ_LATENCY 1, 2 and 3.
// Latency : all three instances share stimulus; each has its own memory model.
// Backpres: fixed-length directed sequences, no open-ended waits.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_wmask;

    logic        if_gnt [3];
    logic        if_rvalid [3];
    logic        d_gnt [3];
    logic        d_rvalid [3];
    logic [31:0] if_rdata [3];
    logic [31:0] d_rdata [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];
    logic [3:0]  mem_wmask [3];
`ifdef MEM_PORT_ARBITER_STATS_EN
    logic [31:0] st_conf [3];
    logic [31:0] st_wins [3];
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = g + 1;
        logic [31:0] mem [256];
        logic [31:0] rd_pipe [LAT];

        always @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[g][b]) mem[mem_addr[g][9:2]][b*8 +: 8] <= mem_wdata[g][b*8 +: 8];
            end
            rd_pipe[0] <= mem[mem_addr[g][9:2]];
            for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
        assign mem_rdata[g] = rd_pipe[LAT-1];

        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .READ_LATENCY(LAT), .STARVE_LIMIT(3)
        ) u_dut (
            .clk_i       (clk),
            .reset_n_i   (rst_n),
            .if_req_i    (if_req),
            .if_addr_i   (if_addr),
            .if_gnt_o    (if_gnt[g]),
            .if_rvalid_o (if_rvalid[g]),
            .if_rdata_o  (if_rdata[g]),
            .d_req_i     (d_req),
            .d_addr_i    (d_addr),
            .d_wmask_i   (d_wmask),
            .d_wdata_i   (d_wdata),
            .d_gnt_o     (d_gnt[g]),
            .d_rvalid_o  (d_rvalid[g]),
            .d_rdata_o   (d_rdata[g]),
            .mem_addr_o  (mem_addr[g]),
            .mem_wmask_o (mem_wmask[g]),
            .mem_wdata_o (mem_wdata[g]),
            .mem_rdata_i (mem_rdata[g])
`ifdef MEM_PORT_ARBITER_STATS_EN
            ,
            .stat_conflicts_o   (st_conf[g]),
            .stat_starve_wins_o (st_wins[g])
`endif
        );
    end

    // Initial memory contents: word index tagged with 0xA0000000.
    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hA000_0000 | 32'(a[9:2]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic prev_i, prev_d, exp_i;
        int   k;
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        repeat (3) @(posedge clk);
        #1;
        // Requests during reset must not be granted.
        if_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        chk("rst_if_gnt", 64'(if_gnt[0]), 64'd0);
        chk("rst_d_gnt", 64'(d_gnt[0]), 64'd0);
        chk("rst_wmask", 64'(mem_wmask[0]), 64'd0);
        chk("rst_addr", 64'(mem_addr[0]), 64'd0);
        chk("rst_if_rv", 64'(if_rvalid[0]), 64'd0);
        chk("rst_d_rdata", 64'(d_rdata[0]), 64'd0);
        if_req = 1'b0; d_req = 1'b0;
        step();
        rst_n = 1'b1;

        // 1: fetch-only reads of 0x00, 0x04, 0x08 (latency 1).
        for (int c = 0; c < 4; c++) begin
            if_req  = (c < 3);
            if_addr = 32'(4 * c);
            @(negedge clk);
            chk("t1_if_gnt", 64'(if_gnt[0]), 64'(c < 3));
            chk("t1_d_rv", 64'(d_rvalid[0]), 64'd0);
            chk("t1_if_rv", 64'(if_rvalid[0]), 64'(c > 0));
            if (c > 0) chk("t1_if_rdata", 64'(if_rdata[0]), 64'(word(32'(4 * (c - 1)))));
            step();
        end
        if_req = 1'b0;

        // 2: data write then read-back of 0x100.
        d_req = 1'b1; d_addr = 32'h100; d_wmask = 4'hF; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t2_w_gnt", 64'(d_gnt[0]), 64'd1);
        chk("t2_w_mask", 64'(mem_wmask[0]), 64'hF);
        chk("t2_w_data", 64'(mem_wdata[0]), 64'hDEAD_BEEF);
        chk("t2_w_addr", 64'(mem_addr[0]), 64'h100);
        step();
        d_wmask = 4'h0;
        @(negedge clk);
        chk("t2_r_gnt", 64'(d_gnt[0]), 64'd1);
        chk("t2_r_mask", 64'(mem_wmask[0]), 64'd0);
        chk("t2_w_no_rv", 64'(d_rvalid[0]), 64'd0);
        step();
        d_req = 1'b0;
        @(negedge clk);
        chk("t2_d_rv", 64'(d_rvalid[0]), 64'd1);
        chk("t2_d_rdata", 64'(d_rdata[0]), 64'hDEAD_BEEF);
        chk("t2_if_hold", 64'(if_rdata[0]), 64'(word(32'h8)));
        chk("t2_idle_mask", 64'(mem_wmask[0]), 64'd0);
        chk("t2_idle_addr", 64'(mem_addr[0]), 64'h100);
        step();

        // 3: both requesting for 8 cycles, expect D,D,D,I repeating.
        if_req = 1'b1; d_req = 1'b1; if_addr = 32'h10; d_addr = 32'h20; d_wmask = 4'h0;
        prev_i = 1'b0; prev_d = 1'b0;
        for (int c = 0; c < 8; c++) begin
            exp_i = ((c % 4) == 3);
            @(negedge clk);
            chk("t3_if_gnt", 64'(if_gnt[0]), 64'(exp_i));
            chk("t3_d_gnt", 64'(d_gnt[0]), 64'(!exp_i));
            chk("t3_if_rv", 64'(if_rvalid[0]), 64'(prev_i));
            chk("t3_d_rv", 64'(d_rvalid[0]), 64'(prev_d));
            if (prev_i) chk("t3_if_rdata", 64'(if_rdata[0]), 64'(word(32'h10)));
            if (prev_d) chk("t3_d_rdata", 64'(d_rdata[0]), 64'(word(32'h20)));
            prev_i = exp_i; prev_d = !exp_i;
            step();
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("t3_last_if_rv", 64'(if_rvalid[0]), 64'(prev_i));
        chk("t3_last_d_rv", 64'(d_rvalid[0]), 64'(prev_d));
`ifdef MEM_PORT_ARBITER_STATS_EN
        // 6: statistics after the 8-cycle conflict run.
        chk("t6_conflicts", 64'(st_conf[0]), 64'd8);
        chk("t6_starve_wins", 64'(st_wins[0]), 64'd2);
`endif
        repeat (4) step();

        // 4: alternating I/D reads every cycle, latency 3.
        for (int c = 0; c < 10; c++) begin
            if (c < 6) begin
                if_req = (c % 2 == 0); d_req = (c % 2 == 1);
                if_addr = 32'h40 + 32'(4 * c); d_addr = 32'h80 + 32'(4 * c);
            end else begin
                if_req = 1'b0; d_req = 1'b0;
            end
            @(negedge clk);
            if (c < 6) begin
                chk("t4_if_gnt", 64'(if_gnt[2]), 64'(c % 2 == 0));
                chk("t4_d_gnt", 64'(d_gnt[2]), 64'(c % 2 == 1));
            end
            if (c >= 3 && c < 9) begin
                k = c - 3;
                chk("t4_if_rv", 64'(if_rvalid[2]), 64'(k % 2 == 0));
                chk("t4_d_rv", 64'(d_rvalid[2]), 64'(k % 2 == 1));
                if (k % 2 == 0) chk("t4_if_rdata", 64'(if_rdata[2]), 64'(word(32'h40 + 32'(4 * k))));
                else            chk("t4_d_rdata", 64'(d_rdata[2]), 64'(word(32'h80 + 32'(4 * k))));
            end else begin
                chk("t4_idle_if_rv", 64'(if_rvalid[2]), 64'd0);
                chk("t4_idle_d_rv", 64'(d_rvalid[2]), 64'd0);
            end
            step();
        end
        repeat (4) step();

        // 5: reset with two reads in flight, latency 2.
        if_req = 1'b1; if_addr = 32'h0; d_req = 1'b0;
        @(negedge clk);
        chk("t5_if_gnt", 64'(if_gnt[1]), 64'd1);
        step();
        if_req = 1'b0; d_req = 1'b1; d_addr = 32'h4; d_wmask = 4'h0;
        @(negedge clk);
        chk("t5_d_gnt", 64'(d_gnt[1]), 64'd1);
        step();
        rst_n = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("t5_rst_if_rv", 64'(if_rvalid[1]), 64'd0);
        chk("t5_rst_d_rv", 64'(d_rvalid[1]), 64'd0);
        chk("t5_rst_if_gnt", 64'(if_gnt[1]), 64'd0);
        chk("t5_rst_d_gnt", 64'(d_gnt[1]), 64'd0);
        chk("t5_rst_addr", 64'(mem_addr[1]), 64'd0);
        chk("t5_rst_wmask", 64'(mem_wmask[1]), 64'd0);
        chk("t5_rst_wdata", 64'(mem_wdata[1]), 64'd0);
        chk("t5_rst_if_rdata", 64'(if_rdata[1]), 64'd0);
        chk("t5_rst_d_rdata", 64'(d_rdata[1]), 64'd0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t5_post_if_rv", 64'(if_rvalid[1]), 64'd0);
            chk("t5_post_d_rv", 64'(d_rvalid[1]), 64'd0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory (BRAM, fixed read latency) between the CPU instruction-fetch port and the data-access port.
- Sits between the cpu top level and the memory macro.
- Performs per-cycle request/grant arbitration with data priority and a fetch anti-starvation counter.
- Routes read data back to the granted requester after the memory latency.

Parameters:
- ADDR_W, 32, address width in bits (byte address).
- DATA_W, 32, data width; write mask has DATA_W/8 bits.
- READ_LATENCY, 1, memory cycles from address to read data (1..4).
- STARVE_LIMIT, 3, consecutive fetch denials after which fetch wins (1..15).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- if_req_i  in  1  fetch request; held until if_gnt_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch read data valid.
- if_rdata_o  out  DATA_W  fetch read data.
- d_req_i  in  1  data request; held until d_gnt_o.
- d_addr_i  in  ADDR_W  data address.
- d_wmask_i  in  DATA_W/8  byte write mask; zero means read.
- d_wdata_i  in  DATA_W  write data.
- d_gnt_o  out  1  data request accepted this cycle.
- d_rvalid_o  out  1  data read data valid (reads only).
- d_rdata_o  out  DATA_W  data read data.
- mem_addr_o  out  ADDR_W  shared memory address.
- mem_wmask_o  out  DATA_W/8  shared write mask; zero when no write is granted.
- mem_wdata_o  out  DATA_W  shared write data.
- mem_rdata_i  in  DATA_W  memory read data, READ_LATENCY cycles after address.

Behaviour:
- Reset: all gnt/rvalid outputs 0; mem_wmask_o 0; mem_addr_o/mem_wdata_o/rdata outputs 0; starvation counter 0; response pipeline cleared.
- Grant is combinational from the requests and the registered counter. At most one gnt_o is high per cycle.
- The mem_* outputs mirror the granted requester's address, mask and data. With no grant, mem_addr_o holds its last value and mem_wmask_o is 0.
- Priority rule:
  - d_req_i only: data granted.
  - if_req_i only: fetch granted.
  - Both requesting: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- Starvation counter (4 bits):
  - Increments on each cycle fetch requests and is denied.
  - Clears on a fetch grant, or on any cycle if_req_i is low.
  - Saturates at STARVE_LIMIT.
- Response tracking:
  - A READ_LATENCY-deep shift register carries {valid, source} per granted read.
  - A data write (nonzero mask) pushes valid=0.
  - At the pipeline tail with valid=1, the matching rvalid_o pulses for one cycle, and that rdata_o = mem_rdata_i.
  - The non-matching rdata_o holds its previous value.
- Back-to-back grants to alternating sources are allowed every cycle; full throughput, no bubbles.
- Reset mid-operation: in-flight responses are discarded and no rvalid is issued. Requesters must re-issue.
- Simultaneous grant and response are independent; the pipeline shifts every cycle.
- Requests are assumed stable while pending. Changing the address before grant is legal; the value at grant time wins.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STATS_EN.
- When defined, adds output stat_conflicts_o (32 bits): counts cycles with both requests asserted.
- Also adds output stat_starve_wins_o (32 bits): counts fetch grants forced by the starvation limit.
- Both counters reset to 0, increment by 1, and wrap modulo 2^32.
- When undefined, the ports and counters are absent and the logic is otherwise identical.

Test Plan:
1. Reset, then fetch-only reads to 0x00, 0x04, 0x08 over consecutive cycles:
   - if_gnt_o high each cycle.
   - if_rvalid_o high 1 cycle later, carrying the stored words.
   - d_rvalid_o stays 0.
2. Data write 0xDEADBEEF to 0x100 with mask 0xF, then data read of 0x100:
   - Write cycle: mem_wmask_o = 0xF and no rvalid for the write.
   - Read: d_rvalid_o returns 0xDEADBEEF.
3. Both requesting continuously, STARVE_LIMIT = 3:
   - Grant pattern D,D,D,I repeating.
   - Each if_rvalid_o/d_rvalid_o is routed to the correct source.
4. READ_LATENCY = 3, alternating I/D reads every cycle:
   - Responses arrive exactly 3 cycles after their grants, in order, with correct source.
5. Assert reset_n_i low while 2 reads are in flight (READ_LATENCY = 2), release after 1 cycle:
   - No rvalid pulses occur.
   - All outputs are at reset values during reset.
6. With MEM_PORT_ARBITER_STATS_EN, run scenario 3 for 8 cycles:
   - stat_conflicts_o = 8.
   - stat_starve_wins_o = 2.
